// File: rtl/uart_rx_if.sv
// Host-side bundle of the 8N1 receiver: serial line in, byte/flag handshake out,
// plus two debug taps (FSM state and the stop-bit sampling strobe).
interface uart_rx_if;
    logic       uart_rx_i;
    logic       uart_rd_i;
    logic [7:0] uart_dat_o;
    logic       uart_avail_o;
    logic       uart_ovr_o;
    logic       uart_ferr_o;
    logic       uart_busy;
    logic [2:0] dbg_state;
    logic       dbg_stop_smp;

    // Handshake: uart_avail_o stays high while uart_dat_o holds an unread byte; a
    // one-cycle uart_rd_i consumes it and clears the sticky flags on the next edge.
    modport slave (
        input  uart_rx_i,
        input  uart_rd_i,
        output uart_dat_o,
        output uart_avail_o,
        output uart_ovr_o,
        output uart_ferr_o,
        output uart_busy,
        output dbg_state,
        output dbg_stop_smp
    );

    modport master (
        output uart_rx_i,
        output uart_rd_i,
        input  uart_dat_o,
        input  uart_avail_o,
        input  uart_ovr_o,
        input  uart_ferr_o,
        input  uart_busy,
        input  dbg_state,
        input  dbg_stop_smp
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling from a fractional tick accumulator,
// single mid-bit sampling, held output byte and sticky overrun/framing flags.
module uart_rx #(
    parameter int clkFreq  = 100000000,
    parameter int baudRate = 115200
) (
    input  logic      sys_clk_i,
    input  logic      sys_rst_i,
    uart_rx_if.slave  rx_bus
);

    localparam logic [28:0] INC_C = 29'(16 * baudRate);
    localparam logic [28:0] DEC_C = 29'(16 * baudRate - clkFreq);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [28:0] acc_q, acc_d;
    logic        tick;
    logic [3:0]  tcnt_q, tcnt_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dat_q, dat_d;
    logic        avail_q, avail_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;
    logic        deliver, frame_err, stop_smp;

    // Bit 28 set means the accumulator is "negative": wait without ticking.
    assign tick  = ~acc_q[28];
    assign acc_d = acc_q[28] ? (acc_q + INC_C) : (acc_q + DEC_C);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            acc_q     <= '0;
            state_q   <= WAIT_IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            dat_q     <= '0;
            avail_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_bus.uart_rx_i;
            rx_s_q    <= rx_meta_q;
            acc_q     <= acc_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            dat_q     <= dat_d;
            avail_q   <= avail_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        frame_err = 1'b0;
        stop_smp  = 1'b0;
        if (tick) begin
            case (state_q)
                // tcnt doubles as the consecutive-high counter here.
                WAIT_IDLE: begin
                    if (rx_s_q) begin
                        tcnt_d = tcnt_q + 4'd1;
                        if (tcnt_q == 4'd15) begin
                            tcnt_d  = 4'd0;
                            state_d = IDLE;
                        end
                    end else begin
                        tcnt_d = 4'd0;
                    end
                end
                IDLE: begin
                    if (!rx_s_q) begin
                        tcnt_d  = 4'd0;
                        state_d = START;
                    end
                end
                START: begin
                    if (tcnt_q == 4'd7) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            tcnt_d  = 4'd0;
                            bcnt_d  = 3'd0;
                            state_d = DATA;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
                DATA: begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) state_d = STOP;
                    end
                end
                STOP: begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        stop_smp = 1'b1;
                        if (rx_s_q) begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_err = 1'b1;
                            tcnt_d    = 4'd0;
                            state_d   = WAIT_IDLE;
                        end
                    end
                end
                default: begin
                    tcnt_d  = 4'd0;
                    state_d = WAIT_IDLE;
                end
            endcase
        end
    end

    // A read clears the flags first; a same-cycle delivery or framing error then wins.
    always_comb begin
        dat_d   = dat_q;
        avail_d = avail_q;
        ovr_d   = ovr_q;
        ferr_d  = ferr_q;
        if (rx_bus.uart_rd_i) begin
            ferr_d = 1'b0;
            if (avail_q) begin
                avail_d = 1'b0;
                ovr_d   = 1'b0;
            end
        end
        if (deliver) begin
            dat_d   = shift_q;
            avail_d = 1'b1;
            if (avail_q && !rx_bus.uart_rd_i) ovr_d = 1'b1;
        end
        if (frame_err) ferr_d = 1'b1;
    end

    assign rx_bus.uart_dat_o   = dat_q;
    assign rx_bus.uart_avail_o = avail_q;
    assign rx_bus.uart_ovr_o   = ovr_q;
    assign rx_bus.uart_ferr_o  = ferr_q;
    assign rx_bus.uart_busy    = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign rx_bus.dbg_state    = state_q;
    assign rx_bus.dbg_stop_smp = stop_smp;

endmodule
